fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage of the RISC-V core. Owns the program counter and drives the word
//  address into the combinational-read instruction memory. Captures the returned instruction
//  into the IF/ID pipeline register and hands it to decode with a valid/ready handshake.
//  Handles branch/jump redirects (flushing IF/ID), halt, and downstream stalls.
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  PC loaded on reset
//  IMEM_WORDS    128            instruction memory depth in 32-bit words; PC >= IMEM_WORDS*4 is out of range
// PORTS
//  clock            in   1   core clock, rising edge
//  reset            in   1   asynchronous, active-high reset
//  instr_mem_addr   out  32  byte address to instruction memory; always equals pc
//  instruction      in   32  instruction memory read data; valid in the same cycle as instr_mem_addr
//  redirect_valid   in   1   branch/jump taken or trap; load redirect_pc
//  redirect_pc      in   32  redirect target (byte address)
//  halt_req         in   1   stop fetching after the current cycle
//  id_ready         in   1   decode accepts the IF/ID entry this cycle
//  id_valid         out  1   IF/ID entry valid
//  id_instr         out  32  IF/ID instruction
//  id_pc            out  32  PC of id_instr
//  id_pc_plus4      out  32  id_pc + 4, modulo 2^32
//  fetch_fault      out  1   IF/ID sideband: entry was fetched from an out-of-range PC
//  misaligned_trap  out  1   pulse: redirect target misaligned (FETCH_MISALIGN_TRAP_EN only)
//  halted           out  1   stage is in HALTED
//  fetch_count      out  32  count of entries written into IF/ID; wraps at 2^32
// BEHAVIOUR
//  Reset (asynchronous, any cycle, including mid-stall or mid-redirect):
//   - pc = RESET_VECTOR; state = BOOT.
//   - id_valid, id_instr, id_pc, id_pc_plus4, fetch_fault, misaligned_trap, halted, fetch_count = 0.
//  States:
//   - BOOT: exactly 1 cycle after reset deasserts; no capture; -> FETCH.
//   - FETCH: normal operation.
//   - HALTED: no captures and PC frozen; halted = 1.
//  Transitions:
//   - FETCH -> HALTED: halt_req = 1 and redirect_valid = 0.
//   - HALTED -> FETCH: only on redirect_valid; halt_req is ignored while in HALTED.
//  Advance condition: adv = (state == FETCH) & (~id_valid | id_ready).
//  On every rising edge, the first matching rule applies (priority order):
//   1. redirect_valid (any state): pc <= redirect_pc; id_valid <= 0 (flush; id_ready ignored);
//      no capture this edge.
//   2. adv & ~halt_req: id_instr <= instruction; id_pc <= pc; id_pc_plus4 <= pc + 4;
//      id_valid <= 1; pc <= pc + 4; fetch_count <= fetch_count + 1.
//   3. id_valid & id_ready (no capture): id_valid <= 0.
//   4. Otherwise: hold all registers (stall).
//  Latency:
//   - Instruction at pc appears on id_* on the edge after it is addressed.
//   - A redirect costs 1 bubble: target is addressed in cycle N+1, valid in IF/ID at N+2.
//  Out-of-range fetch (pc >= IMEM_WORDS*4):
//   - Capture proceeds as in rule 2, but id_instr = 32'h0000_0013 (NOP) and fetch_fault = 1.
//   - fetch_fault is otherwise 0 and is updated with every capture.
//  pc + 4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0); there is no wrap flag.
//  id_* outputs are stable while id_valid & ~id_ready (no change while stalled).
// CONFIGURATION
//  FETCH_MISALIGN_TRAP_EN defined:
//   - A redirect with redirect_pc[1:0] != 0 loads no PC.
//   - It flushes IF/ID, pulses misaligned_trap for 1 cycle, and enters HALTED.
//  FETCH_MISALIGN_TRAP_EN undefined:
//   - pc <= {redirect_pc[31:2], 2'b00}; misaligned_trap is tied to 0.
// TESTING
//  1. Reset release, id_ready = 1 held, memory[i] = i:
//     -> id_valid rises on the 2nd edge after release with id_pc = 0, id_instr = 0;
//        then id_pc = 4, 8, ... one per cycle; fetch_count increments each cycle.
//  2. id_ready = 0 for 3 cycles while id_pc = 8:
//     -> id_* held at pc 8; instr_mem_addr = 12 throughout; no entry lost or duplicated
//        after id_ready returns to 1.
//  3. redirect_valid = 1 with redirect_pc = 32'h40 while id_ready = 0:
//     -> next cycle id_valid = 0 and instr_mem_addr = 32'h40;
//        following cycle id_pc = 32'h40.
//  4. halt_req pulse -> halted = 1, PC frozen, last entry drained by id_ready;
//     redirect_pc = 32'h10 -> halted = 0 and fetch resumes at 32'h10.
//  5. redirect to 32'h200 with IMEM_WORDS = 128:
//     -> id_instr = 32'h0000_0013 and fetch_fault = 1; redirect back to 0 -> fetch_fault = 0.
//  6. Assert reset mid-stall; redirect_pc = 32'h6:
//     -> reset: all outputs 0, pc = RESET_VECTOR.
//     -> redirect, with macro: misaligned_trap pulse and HALTED.
//     -> redirect, without macro: fetch from 32'h4.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction memory port, redirect/halt controls and the IF/ID handshake.
// master = fetch stage, slave = surrounding core (memory, execute/trap unit, decode).
interface fetch_stage_if;
  logic [31:0] instr_mem_addr;
  logic [31:0] instruction;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        fetch_fault;
  logic        misaligned_trap;
  logic        halted;
  logic [31:0] fetch_count;

  modport master (
    output instr_mem_addr, id_valid, id_instr, id_pc, id_pc_plus4,
           fetch_fault, misaligned_trap, halted, fetch_count,
    input  instruction, redirect_valid, redirect_pc, halt_req, id_ready
  );

  modport slave (
    input  instr_mem_addr, id_valid, id_instr, id_pc, id_pc_plus4,
           fetch_fault, misaligned_trap, halted, fetch_count,
    output instruction, redirect_valid, redirect_pc, halt_req, id_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// RISC-V instruction-fetch stage: PC, IF/ID register, redirect/halt/stall handling.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect traps and halts instead of aligning.
module fetch_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          IMEM_WORDS   = 128
) (
  input logic           clock,
  input logic           reset,
  fetch_stage_if.master bus
);

  localparam int          DATA_W     = 32;
  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS * 4);
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  localparam logic [1:0] ST_BOOT   = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0]        state_p0;
  logic [DATA_W-1:0] pc_p0;
  logic              vld_p1;
  logic [DATA_W-1:0] instr_p1;
  logic [DATA_W-1:0] pc_p1;
  logic [DATA_W-1:0] pc_plus4_p1;
  logic              fault_p1;
  logic [DATA_W-1:0] count_p1;
  logic              adv;

  function automatic logic out_of_range(input logic [DATA_W-1:0] addr);
    return addr >= IMEM_LIMIT;
  endfunction

  // Out-of-range fetches deliver a NOP so decode never sees undefined memory data.
  function automatic logic [DATA_W-1:0] fetch_word(input logic [DATA_W-1:0] addr,
                                                   input logic [DATA_W-1:0] data);
    return out_of_range(addr) ? NOP_INSTR : data;
  endfunction

  assign adv = (state_p0 == ST_FETCH) && (!vld_p1 || bus.id_ready);

`ifdef FETCH_MISALIGN_TRAP_EN
  logic trap_p1;
`endif

  // Stage p0 (PC / state) -> p1 (IF/ID register)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_p0    <= ST_BOOT;
      pc_p0       <= RESET_VECTOR;
      vld_p1      <= 1'b0;
      instr_p1    <= '0;
      pc_p1       <= '0;
      pc_plus4_p1 <= '0;
      fault_p1    <= 1'b0;
      count_p1    <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      trap_p1     <= 1'b0;
`endif
    end else begin
`ifdef FETCH_MISALIGN_TRAP_EN
      trap_p1 <= 1'b0;
`endif
      if (bus.redirect_valid) begin
        vld_p1 <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (bus.redirect_pc[1:0] != 2'b00) begin
          trap_p1  <= 1'b1;
          state_p0 <= ST_HALTED;
        end else begin
          pc_p0    <= bus.redirect_pc;
          state_p0 <= ST_FETCH;
        end
`else
        pc_p0    <= bus.redirect_pc & ~32'h3;
        state_p0 <= ST_FETCH;
`endif
      end else begin
        case (state_p0)
          ST_BOOT:  state_p0 <= ST_FETCH;
          ST_FETCH: if (bus.halt_req) state_p0 <= ST_HALTED;
          default:  state_p0 <= state_p0;
        endcase

        if (adv && !bus.halt_req) begin
          instr_p1    <= fetch_word(pc_p0, bus.instruction);
          fault_p1    <= out_of_range(pc_p0);
          pc_p1       <= pc_p0;
          pc_plus4_p1 <= pc_p0 + 32'd4;
          vld_p1      <= 1'b1;
          pc_p0       <= pc_p0 + 32'd4;
          count_p1    <= count_p1 + 32'd1;
        end else if (vld_p1 && bus.id_ready) begin
          vld_p1 <= 1'b0;
        end
      end
    end
  end

  assign bus.instr_mem_addr = pc_p0;
  assign bus.id_valid       = vld_p1;
  assign bus.id_instr       = instr_p1;
  assign bus.id_pc          = pc_p1;
  assign bus.id_pc_plus4    = pc_plus4_p1;
  assign bus.fetch_fault    = fault_p1;
  assign bus.halted         = (state_p0 == ST_HALTED);
  assign bus.fetch_count    = count_p1;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign bus.misaligned_trap = trap_p1;
`else
  assign bus.misaligned_trap = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: boot, stall, redirect, halt, out-of-range and wrap, reset.
// Memory model: word i holds the value i.
module tb_fetch_stage;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  fetch_stage_if bus ();

  fetch_stage #(.RESET_VECTOR(32'h0), .IMEM_WORDS(128)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always_comb bus.instruction = bus.instr_mem_addr >> 2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Full IF/ID view plus the memory address.
  task automatic chk_id(input string tag, input logic vld, input logic [31:0] pc,
                        input logic [31:0] instr, input logic [31:0] cnt, input logic [31:0] addr);
    check({tag, ".vld"},   {31'b0, bus.id_valid}, {31'b0, vld});
    check({tag, ".addr"},  bus.instr_mem_addr, addr);
    check({tag, ".count"}, bus.fetch_count, cnt);
    if (vld) begin
      check({tag, ".pc"},    bus.id_pc, pc);
      check({tag, ".instr"}, bus.id_instr, instr);
      check({tag, ".pc4"},   bus.id_pc_plus4, pc + 32'd4);
    end
  endtask

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.halt_req       = 1'b0;
    bus.id_ready       = 1'b1;

    // Reset state
    #1;
    chk_id("rst", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    check("rst.halted", {31'b0, bus.halted}, 32'h0);
    check("rst.trap",   {31'b0, bus.misaligned_trap}, 32'h0);
    check("rst.fault",  {31'b0, bus.fetch_fault}, 32'h0);
    step(); step();
    reset = 1'b0;

    // 1. Boot then streaming
    step(); chk_id("boot", 1'b0, 32'h0, 32'h0, 32'd0, 32'h0);
    step(); chk_id("f0",   1'b1, 32'h0, 32'd0, 32'd1, 32'h4);
    step(); chk_id("f4",   1'b1, 32'h4, 32'd1, 32'd2, 32'h8);
    step(); chk_id("f8",   1'b1, 32'h8, 32'd2, 32'd3, 32'hC);

    // 2. Downstream stall for 3 cycles
    bus.id_ready = 1'b0;
    step(); chk_id("st1", 1'b1, 32'h8, 32'd2, 32'd3, 32'hC);
    step(); chk_id("st2", 1'b1, 32'h8, 32'd2, 32'd3, 32'hC);
    step(); chk_id("st3", 1'b1, 32'h8, 32'd2, 32'd3, 32'hC);
    bus.id_ready = 1'b1;
    step(); chk_id("rs12", 1'b1, 32'hC,  32'd3, 32'd4, 32'h10);
    step(); chk_id("rs16", 1'b1, 32'h10, 32'd4, 32'd5, 32'h14);

    // 3. Redirect while decode is stalled
    bus.id_ready = 1'b0;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h40;
    step(); chk_id("rd.flush", 1'b0, 32'h0, 32'h0, 32'd5, 32'h40);
    bus.redirect_valid = 1'b0;
    step(); chk_id("rd.tgt",  1'b1, 32'h40, 32'h10, 32'd6, 32'h44);
    step(); chk_id("rd.hold", 1'b1, 32'h40, 32'h10, 32'd6, 32'h44);

    // 4. Halt with a pending entry, drain, resume by redirect
    bus.halt_req = 1'b1;
    step(); chk_id("h.enter", 1'b1, 32'h40, 32'h10, 32'd6, 32'h44);
    check("h.halted1", {31'b0, bus.halted}, 32'h1);
    step(); chk_id("h.hold", 1'b1, 32'h40, 32'h10, 32'd6, 32'h44);
    bus.halt_req = 1'b0;
    bus.id_ready = 1'b1;
    step(); chk_id("h.drain", 1'b0, 32'h0, 32'h0, 32'd6, 32'h44);
    check("h.halted2", {31'b0, bus.halted}, 32'h1);
    step(); chk_id("h.frozen", 1'b0, 32'h0, 32'h0, 32'd6, 32'h44);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h10;
    step(); chk_id("h.wake", 1'b0, 32'h0, 32'h0, 32'd6, 32'h10);
    check("h.halted3", {31'b0, bus.halted}, 32'h0);
    bus.redirect_valid = 1'b0;
    step(); chk_id("h.resume", 1'b1, 32'h10, 32'd4, 32'd7, 32'h14);

    // 5. Out-of-range fetch and the last in-range word
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h200;
    step(); chk_id("oor.addr", 1'b0, 32'h0, 32'h0, 32'd7, 32'h200);
    bus.redirect_valid = 1'b0;
    step(); chk_id("oor.cap", 1'b1, 32'h200, 32'h13, 32'd8, 32'h204);
    check("oor.fault1", {31'b0, bus.fetch_fault}, 32'h1);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h1FC;
    step(); chk_id("edge.addr", 1'b0, 32'h0, 32'h0, 32'd8, 32'h1FC);
    bus.redirect_valid = 1'b0;
    step(); chk_id("edge.last", 1'b1, 32'h1FC, 32'h7F, 32'd9, 32'h200);
    check("edge.fault0", {31'b0, bus.fetch_fault}, 32'h0);
    step(); chk_id("edge.over", 1'b1, 32'h200, 32'h13, 32'd10, 32'h204);
    check("edge.fault1", {31'b0, bus.fetch_fault}, 32'h1);

    // PC wrap at the top of the address space
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
    step(); chk_id("wrap.addr", 1'b0, 32'h0, 32'h0, 32'd10, 32'hFFFF_FFFC);
    bus.redirect_valid = 1'b0;
    step(); chk_id("wrap.cap", 1'b1, 32'hFFFF_FFFC, 32'h13, 32'd11, 32'h0);
    step(); chk_id("wrap.zero", 1'b1, 32'h0, 32'd0, 32'd12, 32'h4);
    check("wrap.fault0", {31'b0, bus.fetch_fault}, 32'h0);

    // 6. Asynchronous reset mid-stall, then misaligned redirect
    bus.id_ready = 1'b0;
    step();
    #2 reset = 1'b1;
    #1;
    chk_id("ar", 1'b0, 32'h0, 32'h0, 32'd0, 32'h0);
    check("ar.pc",     bus.id_pc, 32'h0);
    check("ar.instr",  bus.id_instr, 32'h0);
    check("ar.pc4",    bus.id_pc_plus4, 32'h0);
    check("ar.fault",  {31'b0, bus.fetch_fault}, 32'h0);
    check("ar.halted", {31'b0, bus.halted}, 32'h0);
    step();
    reset = 1'b0;
    bus.id_ready = 1'b1;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h6;
    step();
    bus.redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    chk_id("mis.trap", 1'b0, 32'h0, 32'h0, 32'd0, 32'h0);
    check("mis.pulse",  {31'b0, bus.misaligned_trap}, 32'h1);
    check("mis.halt1",  {31'b0, bus.halted}, 32'h1);
    step(); chk_id("mis.after", 1'b0, 32'h0, 32'h0, 32'd0, 32'h0);
    check("mis.pulse0", {31'b0, bus.misaligned_trap}, 32'h0);
    check("mis.halt2",  {31'b0, bus.halted}, 32'h1);
`else
    chk_id("mis.align", 1'b0, 32'h0, 32'h0, 32'd0, 32'h4);
    check("mis.notrap", {31'b0, bus.misaligned_trap}, 32'h0);
    check("mis.halt",   {31'b0, bus.halted}, 32'h0);
    step(); chk_id("mis.fetch", 1'b1, 32'h4, 32'd1, 32'd1, 32'h8);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
